// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column sequencer, row synchroniser,
// per-scan frame capture, multi-key rejection and scan-count debounce.
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic        key_strobe
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL0,
        COL1,
        COL2,
        COL3
    } col_state_t;

    col_state_t       state;
    col_state_t       state_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             sample;

    logic [3:0]  row_meta;
    logic [3:0]  row_s;
    logic [15:0] frame;
    logic [15:0] frame_next;
    logic        frame_done;

    logic [15:0] candidate;
    logic [15:0] cand_next;
    logic [3:0]  count;
    logic [3:0]  cnt_next;
    logic [15:0] eval_frame;
    logic        multi_key;
    logic        publish;

    assign sample = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COL0;
            div   <= '0;
        end else begin
            state <= state_next;
            div   <= div_next;
        end
    end

    always_comb begin
        state_next = state;
        div_next   = div + 1'b1;
        col_out    = 4'b1110;
        if (sample) begin
            div_next = '0;
        end
        unique case (state)
            COL0: begin
                col_out = 4'b1110;
                if (sample) state_next = COL1;
            end
            COL1: begin
                col_out = 4'b1101;
                if (sample) state_next = COL2;
            end
            COL2: begin
                col_out = 4'b1011;
                if (sample) state_next = COL3;
            end
            COL3: begin
                col_out = 4'b0111;
                if (sample) state_next = COL0;
            end
            default: begin
                col_out    = 4'b1110;
                state_next = COL0;
            end
        endcase
    end

    // Each column's sample overwrites its own four frame bits (4r+c).
    always_comb begin
        frame_next = frame;
        if (sample) begin
            unique case (state)
                COL0: {frame_next[12], frame_next[8],
                       frame_next[4],  frame_next[0]}  = ~row_s;
                COL1: {frame_next[13], frame_next[9],
                       frame_next[5],  frame_next[1]}  = ~row_s;
                COL2: {frame_next[14], frame_next[10],
                       frame_next[6],  frame_next[2]}  = ~row_s;
                COL3: {frame_next[15], frame_next[11],
                       frame_next[7],  frame_next[3]}  = ~row_s;
                default: frame_next = frame;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta   <= 4'b1111;
            row_s      <= 4'b1111;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            row_meta   <= row_in;
            row_s      <= row_meta;
            frame      <= frame_next;
            frame_done <= sample && (state == COL3);
        end
    end

    // Clearing the lowest set bit leaves a non-zero value iff 2+ keys.
    assign multi_key  = |(frame & (frame - 16'd1));
    assign eval_frame = multi_key ? 16'h0000 : frame;

    always_comb begin
        cand_next = candidate;
        cnt_next  = count;
        if (eval_frame == candidate) begin
            if (count != DB_MAX) cnt_next = count + 4'd1;
        end else begin
            cand_next = eval_frame;
            cnt_next  = 4'd1;
        end
    end

    assign publish = frame_done && (cnt_next == DB_MAX) &&
                     (cand_next != onehot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            candidate  <= '0;
            count      <= '0;
            onehot     <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_done) begin
                candidate <= cand_next;
                count     <= cnt_next;
            end
            if (publish) begin
                onehot     <= cand_next;
                key_strobe <= (cand_next != 16'h0000);
            end
        end
    end

endmodule
